// File: rtl/muldiv_seq.sv
// Sequential 32-bit divider (DIV/DIVU/REM/REMU) using one restoring step per cycle.
// Divide-by-zero and signed overflow either finish early or follow the full latency.
module muldiv_seq #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;      // dividend bits shift out as quotient bits shift in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_rem_q, is_rem_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] spec_res;
    logic [32:0] trial;
    logic        qbit;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand decode at acceptance time.
    always_comb begin
        accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;
        is_signed = ~op[0];
        a_neg     = is_signed & dividend[31];
        b_neg     = is_signed & divisor[31];
        a_mag     = a_neg ? (~dividend + 32'd1) : dividend;
        b_mag     = b_neg ? (~divisor + 32'd1) : divisor;
        div_zero  = (divisor == 32'd0);
        overflow  = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        special   = div_zero || overflow;
        if (div_zero) begin
            spec_res = op[1] ? dividend : 32'hFFFF_FFFF;
        end else begin
            spec_res = op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        // NOTE: every signal gets its default first so no path through this block can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;

        trial   = {rem_q, quo_q[31]};
        qbit    = (trial >= {1'b0, dvs_q});
        quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    cnt_d      = 5'd31;
                    quo_d      = a_mag;
                    rem_d      = 32'd0;
                    dvs_d      = b_mag;
                    neg_quo_d  = is_signed & (dividend[31] ^ divisor[31]);
                    neg_rem_d  = a_neg;
                    is_rem_d   = op[1];
                    spec_d     = special;
                    spec_res_d = spec_res;
                    if (special && EARLY_OUT) begin
                        state_d  = DONE;
                        result_d = spec_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = qbit ? (trial[31:0] - dvs_q) : trial[31:0];
                quo_d = {quo_q[30:0], qbit};
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                state_d = DONE;
                if (spec_q) begin
                    result_d = spec_res_q;
                end else begin
                    result_d = is_rem_q ? rem_fix : quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase

        // A kill overrides everything, including a start in the same cycle.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            quo_q      <= 32'd0;
            rem_q      <= 32'd0;
            dvs_q      <= 32'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            is_rem_q   <= is_rem_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
